uart_crc8_frame_checker: RTL

Receive-side framing stage placed directly downstream of the UART receiver. Consumes the receiver's one-cycle `received`/`rx_byte` stream and assembles frames of the form SOF, LEN, payload, CRC. Verifies CRC-8 (poly 0x07) over the payload. Buffers the payload and replays good frames byte-by-byte over a valid/ready stream, which feeds the transmit path or application logic; bad frames are discarded and flagged.

---
 rtl/uart_crc8_frame_checker.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_crc8_frame_checker.sv
// uart_crc8_frame_checker: assembles SOF/LEN/payload/CRC-8 frames from a UART byte stream.
// Good payloads are buffered and replayed on a valid/ready stream; bad frames are flagged and dropped.
module uart_crc8_frame_checker #(
  parameter logic [7:0] SOF = 8'h7E,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       timeout_err,
  output logic       overrun,
  output logic [7:0] good_count
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CRC, SEND} state_t;
  state_t r_state, w_next;
  logic [7:0] r_buf [MAX_LEN];
  logic [LW-1:0] r_len, r_idx, r_rd;
  logic [7:0] r_crc, w_crc;
  logic [TW-1:0] r_tmr;
  logic w_timed, w_to, w_hs, w_last, w_ok, w_cerr, w_lerr, w_ovr;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) x = x[7] ? {x[6:0], 1'b0} ^ 8'h07 : {x[6:0], 1'b0};
    return x;
  endfunction

  assign w_timed   = r_state inside {LEN, PAYLOAD, CRC};
  assign w_to      = w_timed && !rx_valid && r_tmr == TW'(TIMEOUT_CYCLES - 1);
  assign w_last    = r_rd == LW'(r_len - 1'b1);
  assign w_hs      = r_state == SEND && out_ready;
  assign w_crc     = crc8(r_crc, rx_data);
  assign out_valid = r_state == SEND;
  assign out_data  = out_valid ? r_buf[r_rd[IW-1:0]] : 8'h00;
  assign out_last  = out_valid && w_last;

  always_comb begin
    w_next = r_state;
    w_ok   = 1'b0;
    w_cerr = 1'b0;
    w_lerr = 1'b0;
    w_ovr  = 1'b0;
    case (r_state)
      HUNT:    w_next = rx_valid && rx_data == SOF ? LEN : HUNT;
      LEN: begin
        if (rx_valid) begin
          w_lerr = rx_data == 8'd0 || rx_data > 8'(MAX_LEN);
          w_next = w_lerr ? HUNT : PAYLOAD;
        end else if (w_to) w_next = HUNT;
      end
      PAYLOAD: begin
        if (rx_valid) w_next = r_idx == LW'(r_len - 1'b1) ? CRC : PAYLOAD;
        else if (w_to) w_next = HUNT;
      end
      CRC: begin
        if (rx_valid) begin
          w_ok   = rx_data == r_crc;
          w_cerr = !w_ok;
          w_next = w_ok ? SEND : HUNT;
        end else if (w_to) w_next = HUNT;
      end
      SEND: begin
        w_ovr  = rx_valid;
        w_next = w_hs && w_last ? HUNT : SEND;
      end
      default: w_next = HUNT;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) r_state <= HUNT;
    else r_state <= w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_rd        <= '0;
      r_crc       <= '0;
      r_tmr       <= '0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      good_count  <= '0;
    end else begin
      frame_ok    <= w_ok;
      crc_err     <= w_cerr;
      len_err     <= w_lerr;
      timeout_err <= w_to;
      overrun     <= w_ovr;
      good_count  <= good_count + {7'd0, w_ok};
      r_tmr       <= w_timed && !rx_valid ? r_tmr + 1'b1 : '0;
      if (r_state == HUNT) begin
        r_crc <= '0;
        r_idx <= '0;
      end
      if (r_state == LEN && rx_valid) r_len <= rx_data[LW-1:0];
      if (r_state == PAYLOAD && rx_valid) begin
        r_idx <= r_idx + 1'b1;
        r_crc <= w_crc;
      end
      if (w_ok) r_rd <= '0;
      else if (w_hs) r_rd <= r_rd + 1'b1;
    end
  end

  // Payload storage needs no reset; contents are only read after a full frame is written.
  always_ff @(posedge clk)
    if (r_state == PAYLOAD && rx_valid) r_buf[r_idx[IW-1:0]] <= rx_data;
endmodule
